// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the multiplexed 7-segment scan driver.
// Glyphs are active low {a,b,c,d,e,f,g,dp} with the decimal point off.
package seg_pkg;

  localparam logic [7:0] GLYPH_0   = 8'h03;
  localparam logic [7:0] GLYPH_1   = 8'h9F;
  localparam logic [7:0] GLYPH_2   = 8'h25;
  localparam logic [7:0] GLYPH_3   = 8'h0D;
  localparam logic [7:0] GLYPH_4   = 8'h99;
  localparam logic [7:0] GLYPH_5   = 8'h49;
  localparam logic [7:0] GLYPH_6   = 8'h41;
  localparam logic [7:0] GLYPH_7   = 8'h1F;
  localparam logic [7:0] GLYPH_8   = 8'h01;
  localparam logic [7:0] GLYPH_9   = 8'h09;
  localparam logic [7:0] GLYPH_A   = 8'h11;
  localparam logic [7:0] GLYPH_B   = 8'hC1;
  localparam logic [7:0] GLYPH_C   = 8'h63;
  localparam logic [7:0] GLYPH_D   = 8'h85;
  localparam logic [7:0] GLYPH_E   = 8'h61;
  localparam logic [7:0] GLYPH_F   = 8'h71;
  localparam logic [7:0] GLYPH_OFF = 8'hFF;
  localparam logic [7:0] ALL_OFF   = 8'hFF;

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [31:0] digits;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  blink;
  } frame_t;

endpackage

// File: rtl/seg_scan_if.sv
// Frame input and display output bundle of the scan driver.
// master = upstream datapath / board, slave = seg_scan_driver.
interface seg_scan_if;
  logic [31:0] digits;
  logic [7:0]  dp_mask;
  logic [7:0]  blank_mask;
  logic [7:0]  blink_mask;
  logic        load;
  logic        frame_sync;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  modport master (
    output digits, dp_mask, blank_mask,
    output blink_mask, load,
    input  frame_sync, seg_en, seg_out
  );

  modport slave (
    input  digits, dp_mask, blank_mask,
    input  blink_mask, load,
    output frame_sync, seg_en, seg_out
  );
endinterface

// File: rtl/seg7_decode.sv
// Hex digit code to active-low 7-segment glyph {a..g}.
// Purely combinational; the caller appends the dp bit.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_OFF[7:1];
    unique case (code)
      4'h0: glyph = GLYPH_0[7:1];
      4'h1: glyph = GLYPH_1[7:1];
      4'h2: glyph = GLYPH_2[7:1];
      4'h3: glyph = GLYPH_3[7:1];
      4'h4: glyph = GLYPH_4[7:1];
      4'h5: glyph = GLYPH_5[7:1];
      4'h6: glyph = GLYPH_6[7:1];
      4'h7: glyph = GLYPH_7[7:1];
      4'h8: glyph = GLYPH_8[7:1];
      4'h9: glyph = GLYPH_9[7:1];
      4'hA: glyph = GLYPH_A[7:1];
      4'hB: glyph = GLYPH_B[7:1];
      4'hC: glyph = GLYPH_C[7:1];
      4'hD: glyph = GLYPH_D[7:1];
      4'hE: glyph = GLYPH_E[7:1];
      4'hF: glyph = GLYPH_F[7:1];
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed 7-segment scan driver with frame-coherent
// capture, per-digit blank/blink/dp and an anti-ghosting guard.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLINK_HZ  = 2,
  parameter int GUARD_CYC = 16
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW =
    (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BLINK_TICKS =
    SCAN_HZ / (2 * BLINK_HZ);
  localparam int BW =
    (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int GW =
    (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

  if (DWELL < 2 || GUARD_CYC >= DWELL) begin : g_bad_guard
    $error("GUARD_CYC must be shorter than the dwell");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("BLINK_HZ too high for SCAN_HZ");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  phase_e        phase_q, phase_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          pending_q, pending_d;
  frame_t        shadow_q, shadow_d;
  logic          frame_sync_q, frame_sync_d;
  logic [7:0]    seg_en_q, seg_en_d;
  logic [7:0]    seg_out_q, seg_out_d;

  logic       tick;
  logic       wrap;
  logic       dark;
  logic [3:0] code;
  logic [6:0] glyph;

  seg7_decode u_dec (
    .code  (code),
    .glyph (glyph)
  );

  always_comb begin
    tick    = presc_q == PW'(DWELL - 1);
    wrap    = tick && (idx_q == 3'd7);
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 3'd1 : idx_q;

    // Registered one cycle early so it is high during the wrap tick,
    // the same cycle in which a coincident load is captured.
    frame_sync_d = (presc_q == PW'(DWELL - 2))
                && (idx_q == 3'd7);

    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (wrap) begin
      pending_d = 1'b0;
      if (pending_q || bus.load) begin
        shadow_d = '{digits: bus.digits,
                     dp:     bus.dp_mask,
                     blank:  bus.blank_mask,
                     blink:  bus.blink_mask};
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    guard_d = guard_q;
    if (tick) begin
      guard_d = GW'(GUARD_CYC);
    end else if (guard_q != '0) begin
      guard_d = guard_q - 1'b1;
    end

    // Outputs are built from next-state so they switch on the same
    // edge as the scan index.
    code = shadow_d.digits[{idx_d, 2'b00} +: 4];
    dark = shadow_d.blank[idx_d]
        || (shadow_d.blink[idx_d] && (phase_d == PH_OFF));

    seg_out_d = dark ? GLYPH_OFF
                     : {glyph, ~shadow_d.dp[idx_d]};
    seg_en_d  = (dark || (guard_d != '0))
              ? ALL_OFF
              : ~(8'b1 << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= PH_ON;
      guard_q      <= '0;
      pending_q    <= 1'b0;
      shadow_q     <= '0;
      frame_sync_q <= 1'b0;
      seg_en_q     <= ALL_OFF;
      seg_out_q    <= GLYPH_OFF;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      guard_q      <= guard_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      frame_sync_q <= frame_sync_d;
      seg_en_q     <= seg_en_d;
      seg_out_q    <= seg_out_d;
    end
  end

  assign bus.frame_sync = frame_sync_q;
  assign bus.seg_en     = seg_en_q;
  assign bus.seg_out    = seg_out_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 10-cycle dwell, 2-cycle guard,
// blink phase flipping every 2 scan ticks.
module tb_seg_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan_driver #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .BLINK_HZ  (25),
    .GUARD_CYC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]     digits;
    logic [7:0]      dp;
    logic [7:0]      blank;
    logic [7:0]      blink;
    logic [7:0][7:0] en;
    logic [7:0][7:0] out;
  } vec_t;

  vec_t vt [4];
  int   pass_n  = 0;
  int   total_n = 0;

  task automatic chk(string name, logic [7:0] act,
                     logic [7:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %02h want %02h",
                  name, act, exp);
  endtask

  task automatic drive(int i);
    bus.digits     = vt[i].digits;
    bus.dp_mask    = vt[i].dp;
    bus.blank_mask = vt[i].blank;
    bus.blink_mask = vt[i].blink;
  endtask

  task automatic wait_fs(int want, string name);
    int n = 0;
    while (bus.frame_sync !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 8'(n), 8'(want));
  endtask

  // Entered at the negedge where frame_sync is high; checks one
  // whole frame of 80 cycles, optionally driving new inputs.
  task automatic check_frame(int vi, int la, int li,
                             int lb, int lj,
                             int nk, int ni);
    int d;
    int pos;
    logic [7:0] exp_en;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      d = (k - 1) / 10;
      pos = (k - 1) % 10;
      exp_en = (pos < 2) ? 8'hFF : vt[vi].en[d];
      chk($sformatf("en v%0d k%0d", vi, k),
          bus.seg_en, exp_en);
      chk($sformatf("out v%0d k%0d", vi, k),
          bus.seg_out, vt[vi].out[d]);
      chk($sformatf("fs v%0d k%0d", vi, k),
          {7'b0, bus.frame_sync}, {7'b0, k == 80});
      chk($sformatf("onehot v%0d k%0d", vi, k),
          8'($countones(~bus.seg_en) <= 1), 8'd1);
      bus.load = 1'b0;
      if (k == la) begin drive(li); bus.load = 1'b1; end
      if (k == lb) begin drive(lj); bus.load = 1'b1; end
      if (k == nk) drive(ni);
    end
  endtask

  initial begin
    // 0: all-zero shadow, 1: 7654_3210, 2: FEDC_BA98 with dp,
    // 3: all 8s with dp on 2, blank 7, blink 0 and 3.
    vt[0] = '{32'h0, 8'h00, 8'h00, 8'h00,
      {8'h7F, 8'hBF, 8'hDF, 8'hEF,
       8'hF7, 8'hFB, 8'hFD, 8'hFE},
      {8'h03, 8'h03, 8'h03, 8'h03,
       8'h03, 8'h03, 8'h03, 8'h03}};
    vt[1] = '{32'h7654_3210, 8'h00, 8'h00, 8'h00,
      {8'h7F, 8'hBF, 8'hDF, 8'hEF,
       8'hF7, 8'hFB, 8'hFD, 8'hFE},
      {8'h1F, 8'h41, 8'h49, 8'h99,
       8'h0D, 8'h25, 8'h9F, 8'h03}};
    vt[2] = '{32'hFEDC_BA98, 8'hFF, 8'h00, 8'h00,
      {8'h7F, 8'hBF, 8'hDF, 8'hEF,
       8'hF7, 8'hFB, 8'hFD, 8'hFE},
      {8'h70, 8'h60, 8'h84, 8'h62,
       8'hC0, 8'h10, 8'h08, 8'h00}};
    // Frames start on multiples of 8 ticks, so the blink phase
    // while digit d is shown is OFF exactly when d is 2,3,6,7.
    vt[3] = '{32'h8888_8888, 8'h04, 8'h80, 8'h09,
      {8'hFF, 8'hBF, 8'hDF, 8'hEF,
       8'hFF, 8'hFB, 8'hFD, 8'hFE},
      {8'hFF, 8'h01, 8'h01, 8'h01,
       8'hFF, 8'h00, 8'h01, 8'h01}};

    drive(0);
    bus.load = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst en", bus.seg_en, 8'hFF);
    chk("rst out", bus.seg_out, 8'hFF);
    chk("rst fs", {7'b0, bus.frame_sync}, 8'h00);
    rst = 1'b0;

    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1 || c == 9) begin
        chk($sformatf("start en c%0d", c), bus.seg_en, 8'hFE);
        chk($sformatf("start out c%0d", c), bus.seg_out, 8'h03);
      end
      if (c == 10 || c == 11)
        chk($sformatf("start guard c%0d", c), bus.seg_en, 8'hFF);
      if (c == 12) begin
        chk("start en d1", bus.seg_en, 8'hFD);
        chk("start out d1", bus.seg_out, 8'h03);
      end
      bus.load = 1'b0;
      if (c == 2) begin drive(1); bus.load = 1'b1; end
    end
    wait_fs(67, "first frame_sync");

    check_frame(1, 35, 2, 0, 0, 0, 0);
    check_frame(2, 80, 3, 0, 0, 0, 0);
    check_frame(3, 20, 1, 50, 2, 0, 0);
    check_frame(2, 0, 0, 0, 0, 10, 1);

    repeat (5) @(negedge clk);
    chk("pre-rst en", bus.seg_en, 8'hFE);
    chk("pre-rst out", bus.seg_out, 8'h00);
    drive(3);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid rst en", bus.seg_en, 8'hFF);
    chk("mid rst out", bus.seg_out, 8'hFF);
    chk("mid rst fs", {7'b0, bus.frame_sync}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst en", bus.seg_en, 8'hFE);
    chk("post rst out", bus.seg_out, 8'h03);
    wait_fs(78, "post rst frame_sync");
    check_frame(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
